// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared encodings and request checks for the load/store unit
package load_store_unit_pkg;

    // funct3 access-size encodings as produced by the decoder
    localparam logic [2:0] BYT_B  = 3'b000;
    localparam logic [2:0] BYT_H  = 3'b001;
    localparam logic [2:0] BYT_W  = 3'b010;
    localparam logic [2:0] BYT_BU = 3'b100;
    localparam logic [2:0] BYT_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10,
        LSU_RSP  = 2'b11
    } lsu_state_e;

    // Stores only exist in B/H/W; loads add the unsigned B/H variants.
    function automatic logic req_legal(input logic is_store, input logic [2:0] typ);
        if (is_store) begin
            return (typ == BYT_B) || (typ == BYT_H) || (typ == BYT_W);
        end
        return (typ == BYT_B) || (typ == BYT_H) || (typ == BYT_W) ||
               (typ == BYT_BU) || (typ == BYT_HU);
    endfunction

    function automatic logic req_aligned(input logic [2:0] typ, input logic [1:0] off);
        case (typ)
            BYT_H, BYT_HU: return !off[0];
            BYT_W:         return off == 2'b00;
            default:       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-enable generation, store lane steering and load extraction
//
// Purely combinational.
//   byt_typ     : funct3 access size/signedness
//   off         : byte offset within the word (addr[1:0])
//   store_data  : raw store operand (rs2)
//   load_word   : word returned by the memory bus
//   be          : byte enables for the addressed lanes
//   store_lanes : store operand replicated across lanes
//   load_data   : shifted and sign/zero-extended load result
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  byt_typ,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    assign shifted = load_word >> {off, 3'b000};

    always_comb begin
        be          = 4'b1111;
        store_lanes = store_data;
        // The low two funct3 bits carry the size for both signed and unsigned forms.
        case (byt_typ[1:0])
            2'b00: begin
                be          = 4'b0001 << off;
                store_lanes = {4{store_data[7:0]}};
            end
            2'b01: begin
                be          = 4'b0011 << off;
                store_lanes = {2{store_data[15:0]}};
            end
            default: begin
                be          = 4'b1111;
                store_lanes = store_data;
            end
        endcase
    end

    always_comb begin
        load_data = shifted;
        case (byt_typ)
            BYT_B:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            BYT_H:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            BYT_BU:  load_data = {24'h0, shifted[7:0]};
            BYT_HU:  load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory load/store responder with bus handshake and timeout
//
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   req_valid/req_ready             : execute-stage request handshake
//   mem_ctl, byt_typ, addr, wdata   : request fields (store flag, funct3, byte address, rs2)
//   rsp_valid, rsp_err, rdata       : one-cycle completion to writeback
//   mem_req/mem_gnt                 : bus request held until granted
//   mem_we, mem_addr, mem_be,
//   mem_wdata                       : registered bus command
//   mem_rvalid, mem_rdata           : read data return
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_ctl,
    input  logic [2:0]  byt_typ,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    lsu_state_e        state_q, state_n;
    logic              ctl_q;
    logic [2:0]        typ_q;
    logic [1:0]        off_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mem_req_q, mem_we_q;
    logic [31:0]       mem_addr_q, mem_wdata_q;
    logic [3:0]        mem_be_q;
    logic              rsp_err_q;
    logic [31:0]       rdata_q;

    logic              req_ok, timeout_hit;
    logic              take_req, take_gnt, take_rvalid, set_err, leave_req;
    logic [2:0]        sel_typ;
    logic [1:0]        sel_off;
    logic [3:0]        al_be;
    logic [31:0]       al_lanes, al_load;

    // While idle the aligner works on the incoming request (to build the bus
    // command); afterwards it works on the captured request (to extract load data).
    assign sel_typ = (state_q == LSU_IDLE) ? byt_typ   : typ_q;
    assign sel_off = (state_q == LSU_IDLE) ? addr[1:0] : off_q;

    lsu_align u_align (
        .byt_typ     (sel_typ),
        .off         (sel_off),
        .store_data  (wdata),
        .load_word   (mem_rdata),
        .be          (al_be),
        .store_lanes (al_lanes),
        .load_data   (al_load)
    );

    assign req_ok      = req_legal(mem_ctl, byt_typ) && req_aligned(byt_typ, addr[1:0]);
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        take_req    = 1'b0;
        take_gnt    = 1'b0;
        take_rvalid = 1'b0;
        set_err     = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    if (req_ok) begin
                        state_n  = LSU_REQ;
                        take_req = 1'b1;
                    end else begin
                        state_n = LSU_RSP;
                        set_err = 1'b1;
                    end
                end
            end
            LSU_REQ: begin
                // A grant wins over an expiring counter in the same cycle.
                if (mem_gnt) begin
                    take_gnt = 1'b1;
                    state_n  = ctl_q ? LSU_RSP : LSU_WAIT;
                end else if (timeout_hit) begin
                    state_n = LSU_RSP;
                    set_err = 1'b1;
                end
            end
            LSU_WAIT: begin
                if (mem_rvalid) begin
                    take_rvalid = 1'b1;
                    state_n     = LSU_RSP;
                end else if (timeout_hit) begin
                    state_n = LSU_RSP;
                    set_err = 1'b1;
                end
            end
            LSU_RSP: begin
                state_n = LSU_IDLE;
            end
            default: begin
                state_n = LSU_IDLE;
            end
        endcase
    end

    assign leave_req = (state_q == LSU_REQ) && (state_n != LSU_REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q       <= 1'b0;
            typ_q       <= 3'b000;
            off_q       <= 2'b00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            if (take_req) begin
                ctl_q       <= mem_ctl;
                typ_q       <= byt_typ;
                off_q       <= addr[1:0];
                mem_req_q   <= 1'b1;
                mem_we_q    <= mem_ctl;
                mem_addr_q  <= {addr[31:2], 2'b00};
                mem_be_q    <= al_be;
                mem_wdata_q <= al_lanes;
            end
            // Bus command is dropped on grant or on timeout.
            if (leave_req) begin
                mem_req_q   <= 1'b0;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= 32'h0;
                mem_be_q    <= 4'h0;
                mem_wdata_q <= 32'h0;
            end
            if (take_rvalid) begin
                rdata_q <= al_load;
            end
            if (set_err) begin
                rsp_err_q <= 1'b1;
            end
            if (state_q == LSU_RSP) begin
                rsp_err_q <= 1'b0;
                rdata_q   <= 32'h0;
            end
        end
    end

    // Counter restarts on REQ entry and again on WAIT entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (take_req || take_gnt) begin
            cnt_q <= '0;
        end else if ((state_q == LSU_REQ) || (state_q == LSU_WAIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign req_ready = (state_q == LSU_IDLE);
    assign rsp_valid = (state_q == LSU_RSP);
    assign rsp_err   = rsp_err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        mem_ctl = 1'b0;
    logic [2:0]  byt_typ = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        req_ready, rsp_valid, rsp_err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_ctl    (mem_ctl),
        .byt_typ    (byt_typ),
        .addr       (addr),
        .wdata      (wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rdata      (rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access width in bytes, legality, lanes and extension.
    function automatic int m_bytes(input logic [2:0] typ);
        if (typ[1:0] == 2'd0) return 1;
        if (typ[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit m_legal(input bit st, input logic [2:0] typ);
        if (st) return typ <= 3'd2;
        return typ inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] typ, input logic [31:0] a);
        int n;
        logic [7:0] full;
        n = m_bytes(typ);
        full = 8'((1 << n) - 1) << (a % 4);
        return full[3:0];
    endfunction

    function automatic logic [31:0] m_lanes(input logic [2:0] typ, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = m_bytes(typ);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] typ, input logic [31:0] a,
                                           input logic [31:0] word);
        longint v;
        int n;
        n = m_bytes(typ);
        v = longint'(word >> (8 * (a % 4)));
        if (n < 4) begin
            v = v % (longint'(1) << (8 * n));
            if (!typ[2] && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        end
        return v[31:0];
    endfunction

    task automatic issue(input bit st, input logic [2:0] typ, input logic [31:0] a,
                         input logic [31:0] wd);
        req_valid = 1'b1;
        mem_ctl   = st;
        byt_typ   = typ;
        addr      = a;
        wdata     = wd;
        step();
        req_valid = 1'b0;
        mem_ctl   = 1'($urandom);
        byt_typ   = 3'($urandom);
        addr      = $urandom;
        wdata     = $urandom;
    endtask

    task automatic txn(input bit st, input logic [2:0] typ, input logic [31:0] a,
                       input logic [31:0] wd, input int gdly, input int rdly,
                       input logic [31:0] word);
        bit err;
        err = !m_legal(st, typ) || ((a % m_bytes(typ)) != 0);
        chk("ready_before", req_ready, 1);
        issue(st, typ, a, wd);
        if (err) begin
            chk("err_rsp_valid", rsp_valid, 1);
            chk("err_rsp_err", rsp_err, 1);
            chk("err_rdata", rdata, 0);
            chk("err_no_mem_req", mem_req, 0);
            step();
            chk("err_rsp_done", rsp_valid, 0);
            return;
        end
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, st);
        chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
        chk("mem_be", mem_be, m_be(typ, a));
        if (st) chk("mem_wdata", mem_wdata, m_lanes(typ, wd));
        for (int i = 0; i < gdly; i++) begin
            step();
            chk("stall_req", mem_req, 1);
            chk("stall_addr", mem_addr, a & 32'hFFFF_FFFC);
            chk("stall_be", mem_be, m_be(typ, a));
        end
        mem_gnt = 1'b1;
        // rvalid in the grant cycle must be ignored
        mem_rvalid = 1'b1;
        mem_rdata  = ~word;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        chk("req_dropped", mem_req, 0);
        if (st) begin
            chk("st_rsp_valid", rsp_valid, 1);
            chk("st_rsp_err", rsp_err, 0);
            chk("st_rdata", rdata, 0);
        end else begin
            chk("ld_no_early_rsp", rsp_valid, 0);
            for (int i = 0; i < rdly; i++) begin
                step();
                chk("ld_wait", rsp_valid, 0);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = word;
            step();
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            chk("ld_rsp_valid", rsp_valid, 1);
            chk("ld_rsp_err", rsp_err, 0);
            chk("ld_rdata", rdata, m_load(typ, a, word));
        end
        step();
        chk("rsp_one_cycle", rsp_valid, 0);
        chk("ready_after", req_ready, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        step();

        // directed cases
        txn(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0);
        txn(1'b0, 3'b000, 32'h0000_2002, 32'h0, 0, 0, 32'h00F0_0000);
        txn(1'b0, 3'b100, 32'h0000_2002, 32'h0, 0, 0, 32'h00F0_0000);
        txn(1'b0, 3'b010, 32'h0000_2001, 32'h0, 0, 0, 32'h0);
        txn(1'b1, 3'b011, 32'h0000_2000, 32'h1234_5678, 0, 0, 32'h0);
        txn(1'b0, 3'b001, 32'h0000_3002, 32'h0, 5, 0, 32'h8001_0000);
        txn(1'b1, 3'b001, 32'h0000_3002, 32'hDEAD_BEEF, 1, 0, 32'h0);
        txn(1'b1, 3'b010, 32'h0000_3004, 32'hCAFE_F00D, 0, 0, 32'h0);
        txn(1'b0, 3'b101, 32'h0000_3000, 32'h0, 0, 2, 32'h1234_F00D);
        txn(1'b0, 3'b110, 32'h0000_3000, 32'h0, 0, 0, 32'h0);

        // timeout while waiting for grant
        issue(1'b0, 3'b010, 32'h0000_5000, 32'h0);
        for (int i = 0; i < TMO; i++) begin
            chk("to_req_held", mem_req, 1);
            chk("to_req_no_rsp", rsp_valid, 0);
            step();
        end
        chk("to_req_rsp_valid", rsp_valid, 1);
        chk("to_req_rsp_err", rsp_err, 1);
        chk("to_req_mem_req", mem_req, 0);
        chk("to_req_rdata", rdata, 0);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        step();
        mem_rvalid = 1'b0;
        chk("stray_rvalid_ignored", rsp_valid, 0);
        chk("stray_rvalid_ready", req_ready, 1);
        step();
        chk("stray_rvalid_later", rsp_valid, 0);

        // timeout while waiting for read data
        issue(1'b0, 3'b010, 32'h0000_6000, 32'h0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            chk("to_wait_no_rsp", rsp_valid, 0);
            step();
        end
        chk("to_wait_rsp_valid", rsp_valid, 1);
        chk("to_wait_rsp_err", rsp_err, 1);
        chk("to_wait_rdata", rdata, 0);
        step();

        // reset while in WAIT
        issue(1'b0, 3'b010, 32'h0000_4000, 32'h0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_wait_mem_req", mem_req, 0);
        chk("rst_wait_rsp_valid", rsp_valid, 0);
        chk("rst_wait_ready", req_ready, 1);
        step();
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        chk("rst_no_rsp", rsp_valid, 0);
        txn(1'b0, 3'b010, 32'h0000_4000, 32'h0, 0, 0, 32'h8765_4321);

        // randomized traffic
        for (int k = 0; k < 60; k++) begin
            txn(1'($urandom), 3'($urandom), $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
